tdm_mux_tx: RTL and testbench

//  Time-division transmitter for the 8-channel single-bit fan-out path.

---
 rtl/tdm_mux_tx.sv | 115 +++++++++++
 tb/tb_tdm_mux_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_tx.sv
// tdm_mux_tx: captures one parallel 8-channel frame and serialises it as
// one bit per accepted beat, tagging each bit with its slot index.
//
// Ports:
//   clk, reset_n          rising-edge clock, async active-low reset
//   i0..i7                parallel channel inputs, sampled on frame accept
//   in_valid / in_ready   frame handshake (in_ready is combinational on out_ready)
//   y, sel                serial bit and its slot index (channel number)
//   out_valid / out_ready beat handshake
//   frame_last            current beat is the final slot of the frame
module tdm_mux_tx #(
  parameter int unsigned SEL_W   = 3,
  parameter bit          MSB_FST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  input  logic             i6,
  input  logic             i7,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             y,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_last
);

  localparam int unsigned NUM_CH = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] FIRST_SLOT = MSB_FST ? SEL_W'(NUM_CH - 1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST_SLOT  = MSB_FST ? SEL_W'(0) : SEL_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]    slot_q, slot_d;
  logic                y_q, y_d;
  logic                last_q, last_d;
  logic [NUM_CH-1:0]   frame_c;
  logic [SEL_W-1:0]    slot_nxt;
  logic                frame_acc;

  assign frame_c = {i7, i6, i5, i4, i3, i2, i1, i0};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      slot_q   <= '0;
      y_q      <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      y_q      <= y_d;
      last_q   <= last_d;
    end
  end

  // Next-state: frame load takes priority; otherwise advance on beat accept
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    slot_d    = slot_q;
    y_d       = y_q;
    last_d    = last_q;
    slot_nxt  = MSB_FST ? (slot_q - SEL_W'(1)) : (slot_q + SEL_W'(1));
    in_ready  = (state_q == IDLE) | ((state_q == SEND) & last_q & out_ready);
    frame_acc = in_valid & in_ready;

    if (frame_acc) begin
      // Covers both IDLE load and back-to-back reload on the last beat
      state_d  = SEND;
      shadow_d = frame_c;
      slot_d   = FIRST_SLOT;
      y_d      = frame_c[FIRST_SLOT];
      last_d   = (FIRST_SLOT == LAST_SLOT);
    end else begin
      case (state_q)
        SEND: begin
          if (out_ready) begin
            if (last_q) begin
              state_d = IDLE;
              slot_d  = '0;
              y_d     = 1'b0;
              last_d  = 1'b0;
            end else begin
              slot_d = slot_nxt;
              y_d    = shadow_q[slot_nxt];
              last_d = (slot_nxt == LAST_SLOT);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state_q == SEND);
  assign y          = y_q;
  assign sel        = slot_q;
  assign frame_last = last_q;

endmodule

// File: tb/tb_tdm_mux_tx.sv
// Testbench for tdm_mux_tx (slot 0 first): table-driven single frames plus
// hand-written backpressure, back-to-back, isolation and mid-frame reset runs.
module tb_tdm_mux_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i0, i1, i2, i3, i4, i5, i6, i7;
  logic       in_valid, in_ready;
  logic       y;
  logic [2:0] sel;
  logic       out_valid, out_ready, frame_last;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_mux_tx #(.SEL_W(3), .MSB_FST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] frame;  // {i7..i0}
    logic [7:0] exp_y;  // bit k = expected y on beat k
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_frame(input logic [7:0] f);
    {i7, i6, i5, i4, i3, i2, i1, i0} = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one frame with out_ready=1 and check all 8 beats plus the idle after
  task automatic send_frame(input logic [7:0] f, input logic [7:0] exp_y, input string tag);
    set_frame(f);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " sel"}, 32'(sel), 32'(k));
      check({tag, " y"}, 32'(y), 32'(exp_y[k]));
      check({tag, " frame_last"}, 32'(frame_last), 32'(k == 7));
      tick();
    end
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_a3;
    int k;
    int stall;

    vecs[0] = '{frame: 8'b1010_0110, exp_y: 8'b1010_0110};
    vecs[1] = '{frame: 8'h3C,        exp_y: 8'b0011_1100};
    vecs[2] = '{frame: 8'h01,        exp_y: 8'b0000_0001};
    vecs[3] = '{frame: 8'h80,        exp_y: 8'b1000_0000};

    // T1 reset
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_frame(8'hFF);
    tick(); tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst sel", 32'(sel), 32'd0);
    check("rst frame_last", 32'(frame_last), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    // T2 single frames, full throughput
    for (int v = 0; v < 4; v++) send_frame(vecs[v].frame, vecs[v].exp_y, $sformatf("vec%0d", v));

    // T3 backpressure: out_ready low 3 cycles while at sel=3
    set_frame(8'h5A); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0; stall = 0;
    for (int c = 0; c < 11 && k < 8; c++) begin
      out_ready = !(k == 3 && stall < 3);
      #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp sel", 32'(sel), 32'(k));
      check("bp y", 32'(y), 32'(((8'h5A >> k) & 8'h01) != 8'h00));
      if (!out_ready) check("bp in_ready stall", 32'(in_ready), 32'd0);
      if (out_ready) k++; else stall++;
      tick();
    end
    check("bp beat count", 32'(k), 32'd8);
    check("bp stall count", 32'(stall), 32'd3);
    check("bp idle", 32'(out_valid), 32'd0);

    // T4 back-to-back FF then 00, no bubble
    out_ready = 1'b1; set_frame(8'hFF); in_valid = 1'b1;
    tick();
    set_frame(8'h00);
    for (int b = 0; b < 16; b++) begin
      check("b2b out_valid", 32'(out_valid), 32'd1);
      check("b2b sel", 32'(sel), 32'(b % 8));
      check("b2b y", 32'(y), 32'(b < 8));
      if (b == 3) check("b2b in_ready mid", 32'(in_ready), 32'd0);
      if (b == 7) check("b2b in_ready last", 32'(in_ready), 32'd1);
      if (b == 8) in_valid = 1'b0;
      tick();
    end
    check("b2b idle", 32'(out_valid), 32'd0);

    // T5 input isolation: inputs change to 55 during SEND of A3
    exp_a3 = 8'hA3;
    set_frame(8'hA3); in_valid = 1'b1;
    tick();
    set_frame(8'h55);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) in_valid = 1'b0;
      #1;
      check("iso y", 32'(y), 32'(exp_a3[b]));
      check("iso sel", 32'(sel), 32'(b));
      check("iso in_ready", 32'(in_ready), 32'(b == 7));
      tick();
    end
    check("iso idle", 32'(out_valid), 32'd0);

    // T6 reset mid-frame at sel=4, then fresh frame 81
    set_frame(8'hF0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    check("mid sel before rst", 32'(sel), 32'd4);
    reset_n = 1'b0;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst sel", 32'(sel), 32'd0);
    check("mid rst y", 32'(y), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check("post mid rst idle", 32'(out_valid), 32'd0);
    send_frame(8'h81, 8'b1000_0001, "after rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
